// File: rtl/fmap_sram_reader_pkg.sv
// rtl/fmap_sram_reader_pkg.sv - shared types and constants for the feature-map SRAM reader
package fmap_sram_reader_pkg;

  localparam int MEMADDRBIT = 13;
  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [MEMADDRBIT-1:0] r;
    logic [MEMADDRBIT-1:0] c;
    logic [MEMADDRBIT-1:0] i;
  } idx_tag_t;

  // Column fastest, then row, then channel: same walk order as the pooling writer.
  function automatic idx_tag_t next_tag(input idx_tag_t t,
                                        input logic [MEMADDRBIT-1:0] nr,
                                        input logic [MEMADDRBIT-1:0] nc);
    idx_tag_t n;
    n = t;
    if (t.c == nc - 1'b1) begin
      n.c = '0;
      if (t.r == nr - 1'b1) begin
        n.r = '0;
        n.i = t.i + 1'b1;
      end else begin
        n.r = t.r + 1'b1;
      end
    end else begin
      n.c = t.c + 1'b1;
    end
    return n;
  endfunction

endpackage

// File: rtl/fmap_sram_reader_fifo.sv
// rtl/fmap_sram_reader_fifo.sv - 2-entry FIFO of {byte, index tag, last flag}
module fmap_tag_fifo
  import fmap_sram_reader_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  idx_tag_t   push_tag,
  input  logic       push_last,
  input  logic       pop,
  output logic [7:0] head_data,
  output idx_tag_t   head_tag,
  output logic       head_last,
  output logic       head_valid,
  output logic [1:0] count
);

  typedef struct packed {
    logic [7:0] data;
    idx_tag_t   tag;
    logic       last;
  } entry_t;

  entry_t e0;
  entry_t e1;
  entry_t e_in;
  logic   do_pop;
  logic   do_push;

  assign e_in    = '{data: push_data, tag: push_tag, last: push_last};
  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'(FIFO_DEPTH)) || do_pop);

  assign head_data  = e0.data;
  assign head_tag   = e0.tag;
  assign head_last  = e0.last;
  assign head_valid = (count != 2'd0);

  // e0 is always the head; e1 only holds the second entry when full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e0    <= '0;
      e1    <= '0;
      count <= 2'd0;
    end else begin
      case (count)
        2'd0: begin
          if (do_push) begin
            e0    <= e_in;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (do_push && do_pop) begin
            e0 <= e_in;
          end else if (do_push) begin
            e1    <= e_in;
            count <= 2'd2;
          end else if (do_pop) begin
            count <= 2'd0;
          end
        end
        default: begin
          if (do_pop) begin
            e0 <= e1;
            if (do_push) e1 <= e_in;
            else         count <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/fmap_sram_reader.sv
// rtl/fmap_sram_reader.sv - streams a pooled feature map out of the 8-bit SRAM with (row,col,channel) tags
module fmap_sram_reader
  import fmap_sram_reader_pkg::*;
#(
  parameter int memaddrbit = MEMADDRBIT,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [memaddrbit-1:0] base_addr,
  input  logic [memaddrbit-1:0] dr,
  input  logic [memaddrbit-1:0] dc,
  input  logic [memaddrbit-1:0] di,
  output logic                  mem_en,
  output logic [memaddrbit-1:0] mem_addr,
  input  logic [7:0]            mem_rdata,
  output logic [7:0]            dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_last,
  output logic [memaddrbit-1:0] ir_o,
  output logic [memaddrbit-1:0] ic_o,
  output logic [memaddrbit-1:0] ii_o,
  output logic                  busy,
  output logic                  done
);

  if (RD_LAT != 1) begin : g_rd_lat_check
    $error("fmap_sram_reader: only RD_LAT == 1 is supported");
  end
  if (memaddrbit != MEMADDRBIT) begin : g_width_check
    $error("fmap_sram_reader: memaddrbit must match the package tag width");
  end

  state_t                state;
  logic [memaddrbit-1:0] base_q, dr_q, dc_q, di_q, offset;
  idx_tag_t              cur_tag;
  idx_tag_t              last_tag;
  logic                  rd_valid;
  idx_tag_t              rd_tag;
  logic                  rd_last;
  logic                  pop;
  logic [1:0]            fifo_count;
  logic [2:0]            occ_next;
  logic                  can_issue;
  logic                  issue_last;
  logic [7:0]            head_data;
  idx_tag_t              head_tag;
  logic                  head_last;
  logic                  head_valid;

  assign last_tag.r = dr_q - 1'b1;
  assign last_tag.c = dc_q - 1'b1;
  assign last_tag.i = di_q - 1'b1;

  assign pop        = head_valid && dout_ready;
  assign rd_last    = (rd_tag == last_tag);
  assign issue_last = mem_en && (cur_tag == last_tag);

  // Occupancy the next cycle will see (FIFO after this edge plus the read now on the bus);
  // issuing only while it is below 2 keeps the FIFO from overflowing.
  assign occ_next  = {1'b0, fifo_count} + {2'b00, rd_valid} - {2'b00, pop} + {2'b00, mem_en};
  assign can_issue = (occ_next < 3'd2);

  assign dout       = head_data;
  assign dout_valid = head_valid;
  assign dout_last  = head_last;
  assign ir_o       = head_tag.r;
  assign ic_o       = head_tag.c;
  assign ii_o       = head_tag.i;

  // One-stage tag pipeline matching the SRAM read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_tag   <= '0;
    end else begin
      rd_valid <= mem_en;
      rd_tag   <= cur_tag;
    end
  end

  fmap_tag_fifo u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (rd_valid),
    .push_data  (mem_rdata),
    .push_tag   (rd_tag),
    .push_last  (rd_last),
    .pop        (pop),
    .head_data  (head_data),
    .head_tag   (head_tag),
    .head_last  (head_last),
    .head_valid (head_valid),
    .count      (fifo_count)
  );

  // Sweep control; cur_tag always holds the tag of the most recently issued address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mem_en   <= 1'b0;
      mem_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      base_q   <= '0;
      dr_q     <= '0;
      dc_q     <= '0;
      di_q     <= '0;
      offset   <= '0;
      cur_tag  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            base_q  <= base_addr;
            dr_q    <= dr;
            dc_q    <= dc;
            di_q    <= di;
            busy    <= 1'b1;
            cur_tag <= '0;
            if ((dr != '0) && (dc != '0) && (di != '0)) begin
              state    <= READ;
              mem_en   <= 1'b1;
              mem_addr <= base_addr;
              offset   <= memaddrbit'(1);
            end else begin
              state <= DONE;
            end
          end
        end
        READ: begin
          if (issue_last) begin
            mem_en <= 1'b0;
            state  <= DRAIN;
          end else if (can_issue) begin
            mem_en   <= 1'b1;
            mem_addr <= base_q + offset;
            offset   <= offset + 1'b1;
            cur_tag  <= next_tag(cur_tag, dr_q, dc_q);
          end else begin
            mem_en <= 1'b0;
          end
        end
        DRAIN: begin
          if (pop && head_last) state <= DONE;
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fmap_sram_reader.sv
// tb/tb_fmap_sram_reader.sv - self-checking bench for fmap_sram_reader
module tb_fmap_sram_reader;

  logic        clk = 1'b0;
  logic        rst, start, mem_en, dout_valid, dout_ready, dout_last, busy, done;
  logic [12:0] base_addr, dr, dc, di, mem_addr, ir_o, ic_o, ii_o;
  logic [7:0]  mem_rdata = 8'd0;
  logic [7:0]  dout;

  fmap_sram_reader #(.memaddrbit(13), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .dr(dr), .dc(dc), .di(di), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_last(dout_last), .ir_o(ir_o),
    .ic_o(ic_o), .ii_o(ii_o), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // SRAM model: byte at address a is a[7:0], one cycle read latency.
  always @(posedge clk) if (mem_en) mem_rdata <= mem_addr[7:0];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         r, c, i;
    bit         last;
  } beat_t;

  typedef struct {
    int base, dr, dc, di, bp, exp_beats, exp_done_lat;
  } vec_t;

  beat_t exp_beats[$];
  int    exp_addr[$];

  int n_cmp = 0, n_err = 0;
  int beat_cnt = 0, done_cnt = 0, done_cyc = 0, first_en = -1, first_valid = -1;
  int mcnt = 0, prev_en = 0;
  bit held = 0;
  logic [7:0]  h_d;
  logic [12:0] h_r, h_c, h_i;
  logic        h_l;
  beat_t       bt;
  int          a_exp;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic push_exp(input int b, input int nr, input int nc, input int ni);
    int off;
    beat_t e;
    off = 0;
    for (int i = 0; i < ni; i++)
      for (int r = 0; r < nr; r++)
        for (int c = 0; c < nc; c++) begin
          int a;
          a = (b + off) % 8192;
          exp_addr.push_back(a);
          e.data = a[7:0];
          e.r = r; e.c = c; e.i = i;
          e.last = (i == ni - 1) && (r == nr - 1) && (c == nc - 1);
          exp_beats.push_back(e);
          off++;
        end
  endtask

  task automatic check_reset_outputs(input string t);
    chk({t, "_mem_en"}, mem_en, 0);
    chk({t, "_mem_addr"}, mem_addr, 0);
    chk({t, "_dout"}, dout, 0);
    chk({t, "_dout_valid"}, dout_valid, 0);
    chk({t, "_dout_last"}, dout_last, 0);
    chk({t, "_idx"}, {ir_o, ic_o, ii_o}, 0);
    chk({t, "_busy"}, busy, 0);
    chk({t, "_done"}, done, 0);
  endtask

  // Monitor: scoreboard pops, occupancy model, hold stability, done bookkeeping.
  always @(negedge clk) begin
    if (rst) begin
      mcnt = 0; prev_en = 0; held = 0;
    end else begin
      if (mem_en) begin
        if (first_en < 0) first_en = cyc;
        n_cmp++;
        if (mcnt + prev_en >= 2) begin
          n_err++;
          $display("FAIL occupancy: got mem_en with fifo+inflight=%0d want <2", mcnt + prev_en);
        end
        n_cmp++;
        if (exp_addr.size() == 0) begin
          n_err++;
          $display("FAIL mem_addr: got unexpected mem_en addr=%0d want no read", mem_addr);
        end else begin
          a_exp = exp_addr.pop_front();
          if (mem_addr !== 13'(a_exp)) begin
            n_err++;
            $display("FAIL mem_addr: got %0d want %0d", mem_addr, a_exp);
          end
        end
      end
      n_cmp++;
      if (dout_valid !== (mcnt != 0)) begin
        n_err++;
        $display("FAIL dout_valid: got %0b want %0b", dout_valid, (mcnt != 0));
      end
      if (held) begin
        n_cmp++;
        if (!dout_valid || dout !== h_d || ir_o !== h_r || ic_o !== h_c || ii_o !== h_i || dout_last !== h_l) begin
          n_err++;
          $display("FAIL hold: got v=%0b d=%0d (%0d,%0d,%0d) want d=%0d (%0d,%0d,%0d)",
                   dout_valid, dout, ir_o, ic_o, ii_o, h_d, h_r, h_c, h_i);
        end
      end
      if (dout_valid && first_valid < 0) first_valid = cyc;
      if (dout_valid && dout_ready) begin
        beat_cnt++;
        n_cmp++;
        if (exp_beats.size() == 0) begin
          n_err++;
          $display("FAIL beat: got unexpected d=%0d want no beat", dout);
        end else begin
          bt = exp_beats.pop_front();
          if (dout !== bt.data || ir_o !== 13'(bt.r) || ic_o !== 13'(bt.c) || ii_o !== 13'(bt.i) || dout_last !== bt.last) begin
            n_err++;
            $display("FAIL beat: got d=%0d (%0d,%0d,%0d) last=%0b want d=%0d (%0d,%0d,%0d) last=%0b",
                     dout, ir_o, ic_o, ii_o, dout_last, bt.data, bt.r, bt.c, bt.i, bt.last);
          end
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        n_cmp++;
        if (busy !== 1'b0) begin
          n_err++;
          $display("FAIL busy_at_done: got %0b want 0", busy);
        end
      end
      held = dout_valid && !dout_ready;
      h_d = dout; h_r = ir_o; h_c = ic_o; h_i = ii_o; h_l = dout_last;
      mcnt = mcnt + prev_en - ((dout_valid && dout_ready) ? 1 : 0);
      prev_en = mem_en ? 1 : 0;
    end
  end

  task automatic run_vec(input vec_t v);
    int n0, d0, st;
    bit got;
    push_exp(v.base, v.dr, v.dc, v.di);
    n0 = beat_cnt; d0 = done_cnt; first_en = -1; first_valid = -1; got = 0;
    @(posedge clk); #1;
    base_addr = 13'(v.base); dr = 13'(v.dr); dc = 13'(v.dc); di = 13'(v.di);
    start = 1'b1; dout_ready = 1'b1; st = cyc;
    for (int k = 0; k < 400 && !got; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      dout_ready = (v.bp == 0) ? 1'b1 : ((k % 3) == 0);
      if (done_cnt != d0) got = 1;
    end
    dout_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("done_count", done_cnt - d0, 1);
    chk("beats", beat_cnt - n0, v.exp_beats);
    chk("scoreboard_left", exp_beats.size() + exp_addr.size(), 0);
    if (v.exp_done_lat >= 0) begin
      chk("done_latency", done_cyc - st, v.exp_done_lat);
    end else begin
      chk("first_mem_en_latency", first_en - st, 1);
      chk("first_valid_latency", first_valid - st, 3);
    end
  endtask

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int n0, d0;
    bit got;
    rst = 1'b1; start = 1'b0; base_addr = '0; dr = '0; dc = '0; di = '0; dout_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    vecs[0] = '{100,  2, 2, 1, 0, 4,  -1};
    vecs[1] = '{0,    1, 4, 2, 1, 8,  -1};
    vecs[2] = '{8190, 1, 4, 1, 0, 4,  -1};
    vecs[3] = '{10,   3, 0, 2, 0, 0,   2};
    vecs[4] = '{300,  3, 2, 2, 1, 12, -1};
    vecs[5] = '{7,    1, 1, 1, 0, 1,  -1};
    for (int n = 0; n < 6; n++) run_vec(vecs[n]);

    // start while busy must be ignored
    push_exp(200, 1, 4, 2);
    n0 = beat_cnt; d0 = done_cnt; got = 0;
    @(posedge clk); #1;
    base_addr = 13'd200; dr = 13'd1; dc = 13'd4; di = 13'd2; start = 1'b1;
    for (int k = 0; k < 400 && !got; k++) begin
      @(posedge clk); #1;
      start = (k == 3);
      if (k == 3) begin
        chk("busy_mid_sweep", busy, 1);
        base_addr = 13'd0; dr = 13'd3; dc = 13'd3; di = 13'd3;
      end
      if (done_cnt != d0) got = 1;
    end
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("busy_start_done_count", done_cnt - d0, 1);
    chk("busy_start_beats", beat_cnt - n0, 8);
    chk("busy_start_scoreboard_left", exp_beats.size() + exp_addr.size(), 0);

    // reset mid-sweep, then a fresh sweep
    push_exp(0, 1, 4, 2);
    n0 = beat_cnt; d0 = done_cnt;
    @(posedge clk); #1;
    base_addr = 13'd0; dr = 13'd1; dc = 13'd4; di = 13'd2; start = 1'b1;
    for (int k = 0; k < 200 && (beat_cnt - n0) < 3; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    start = 1'b0;
    chk("beats_before_reset", ((beat_cnt - n0) >= 3) ? 1 : 0, 1);
    rst = 1'b1;
    exp_beats.delete();
    exp_addr.delete();
    #1;
    check_reset_outputs("mid_reset");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("mid_reset_hold");
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("no_done_after_reset", done_cnt - d0, 0);
    v = '{50, 2, 2, 1, 0, 4, -1};
    run_vec(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
